// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4:1 TDM receive end: serial input side plus recovered lines and status.
// Defining TDM_DEMUX_TRISTATE_EN adds the oe_n output-enable input.
interface tdm_demux4_if #(
  parameter int unsigned WIDTH = 1
);
  logic             en;
  logic             frame_sync;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] d3;
  logic             frame_valid;
  logic [1:0]       slot;
  logic [3:0]       slot_dec;
  logic             locked;
  logic             sync_err;
`ifdef TDM_DEMUX_TRISTATE_EN
  logic             oe_n;

  modport master (
    output en, frame_sync, din, oe_n,
    input  d0, d1, d2, d3, frame_valid, slot, slot_dec, locked, sync_err
  );
  modport slave (
    input  en, frame_sync, din, oe_n,
    output d0, d1, d2, d3, frame_valid, slot, slot_dec, locked, sync_err
  );
`else
  modport master (
    output en, frame_sync, din,
    input  d0, d1, d2, d3, frame_valid, slot, slot_dec, locked, sync_err
  );
  modport slave (
    input  en, frame_sync, din,
    output d0, d1, d2, d3, frame_valid, slot, slot_dec, locked, sync_err
  );
`endif
endinterface

// File: rtl/tdm_demux4.sv
// 4:1 TDM demultiplexer: rebuilds I0..I3 from the serial mux stream, one atomic update per frame.
// Optional macro TDM_DEMUX_TRISTATE_EN: d0..d3 driven through tri-state buffers gated by oe_n.
module tdm_demux4 #(
  parameter int unsigned WIDTH       = 1,
  parameter int unsigned SLOT_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  localparam int unsigned   CW       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CW-1:0]           cyc_q, cyc_d;
  logic [1:0]              slot_q, slot_d;
  logic [2:0][WIDTH-1:0]   sh_q, sh_d;
  logic [3:0][WIDTH-1:0]   dout_q, dout_d;
  logic                    fv_q, fv_d;
  logic                    err_q, err_d;

  logic [1:0]              eff_slot;
  logic [CW-1:0]           eff_cyc;
  logic [3:0]              eff_dec;
  logic                    active;
  logic                    sample;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    slot_d   = slot_q;
    sh_d     = sh_q;
    dout_d   = dout_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    eff_slot = slot_q;
    eff_cyc  = cyc_q;
    active   = (state_q == LOCKED);
    sample   = 1'b0;

    if (bus.en) begin
      // A sync forces this cycle to slot 0 / cycle 0; it is only an error away from the frame boundary.
      if (bus.frame_sync) begin
        err_d    = (state_q == LOCKED) && !(slot_q == 2'd0 && cyc_q == '0);
        eff_slot = 2'd0;
        eff_cyc  = '0;
        active   = 1'b1;
        state_d  = LOCKED;
      end

      if (active) begin
        sample = (eff_cyc == CYC_LAST);
        if (sample) begin
          cyc_d  = '0;
          slot_d = 2'(eff_slot + 2'd1);
          if (eff_slot == 2'd3) begin
            dout_d = {bus.din, sh_q[2], sh_q[1], sh_q[0]};
            fv_d   = 1'b1;
          end
        end else begin
          cyc_d  = CW'(eff_cyc + 1'b1);
          slot_d = eff_slot;
        end
      end
    end

    eff_dec = 4'b0001 << eff_slot;
    for (int unsigned i = 0; i < 3; i++) begin
      if (sample && eff_dec[i]) sh_d[i] = bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      cyc_q   <= '0;
      slot_q  <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      slot_q  <= slot_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
    end
  end

  assign bus.slot        = slot_q;
  assign bus.slot_dec    = 4'b0001 << slot_q;
  assign bus.locked      = (state_q == LOCKED);
  assign bus.frame_valid = fv_q;
  assign bus.sync_err    = err_q;

`ifdef TDM_DEMUX_TRISTATE_EN
  assign bus.d0 = bus.oe_n ? 'z : dout_q[0];
  assign bus.d1 = bus.oe_n ? 'z : dout_q[1];
  assign bus.d2 = bus.oe_n ? 'z : dout_q[2];
  assign bus.d3 = bus.oe_n ? 'z : dout_q[3];
`else
  assign bus.d0 = dout_q[0];
  assign bus.d1 = dout_q[1];
  assign bus.d2 = dout_q[2];
  assign bus.d3 = dout_q[3];
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: vector table, directed corner sequences, random run vs frame model.
module tb_tdm_demux4;

  localparam int unsigned W     = 1;
  localparam int unsigned SC    = 2;
  localparam int unsigned FRAME = 4 * SC;

  logic clk;
  logic rst_n;

  tdm_demux4_if #(.WIDTH(W)) bus ();

  tdm_demux4 #(.WIDTH(W), .SLOT_CYCLES(SC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: position within the frame as a plain integer.
  int   pos;
  bit   mlocked;
  logic samp [4];
  logic mout [4];
  bit   mfv;
  bit   merr;

  typedef struct {
    bit         en;
    bit         fs;
    bit         din;
    bit         fv;
    bit         err;
    logic [3:0] d;
    logic [1:0] slot;
    bit         lk;
  } vec_t;

  vec_t tbl [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic model_reset();
    pos = 0; mlocked = 0; mfv = 0; merr = 0;
    for (int i = 0; i < 4; i++) begin samp[i] = 1'b0; mout[i] = 1'b0; end
  endtask

  task automatic model_step(input bit e, input bit f, input bit dn);
    mfv  = 0;
    merr = 0;
    if (!e) return;
    if (f) begin
      merr    = mlocked && (pos != 0);
      pos     = 0;
      mlocked = 1;
    end
    if (mlocked) begin
      if ((pos % SC) == SC - 1) begin
        if (pos / SC == 3) begin
          for (int i = 0; i < 3; i++) mout[i] = samp[i];
          mout[3] = dn;
          mfv = 1;
        end else begin
          samp[pos / SC] = dn;
        end
      end
      pos = (pos + 1) % FRAME;
    end
  endtask

  task automatic check_model();
    logic [3:0] expd;
    int         es;
    expd = {mout[3], mout[2], mout[1], mout[0]};
`ifdef TDM_DEMUX_TRISTATE_EN
    if (bus.oe_n) expd = 4'bzzzz;
`endif
    es = pos / SC;
    chk("m_d", {28'd0, bus.d3, bus.d2, bus.d1, bus.d0}, {28'd0, expd});
    chk("m_fv", bus.frame_valid, mfv);
    chk("m_err", bus.sync_err, merr);
    chk("m_slot", bus.slot, es);
    chk("m_dec", bus.slot_dec, 32'd1 << es);
    chk("m_lock", bus.locked, mlocked);
  endtask

  task automatic cyc(input bit e, input bit f, input bit dn);
    bus.en = e; bus.frame_sync = f; bus.din = dn;
    @(posedge clk);
    model_step(e, f, dn);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hit;
    logic [3:0] dhit;
    bit e_s [11] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b1};
    bit d_s [11] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};

    rst_n = 1'b0; bus.en = 1'b0; bus.frame_sync = 1'b0; bus.din = '0;
`ifdef TDM_DEMUX_TRISTATE_EN
    bus.oe_n = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 4'h0);
    chk("rst_dec", bus.slot_dec, 4'b0001);
    chk("rst_lock", bus.locked, 1'b0);
    chk("rst_fv", bus.frame_valid, 1'b0);
    rst_n = 1'b1;

    // Basic frame, freewheel frame, sync exactly at boundary.
    tbl[0]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,4'h0,2'd0,1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b1, 1'b0,1'b0,4'h0,2'd0,1'b1};
    tbl[2]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,4'h0,2'd1,1'b1};
    tbl[3]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'h0,2'd1,1'b1};
    tbl[4]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'h0,2'd2,1'b1};
    tbl[5]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,4'h0,2'd2,1'b1};
    tbl[6]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,4'h0,2'd3,1'b1};
    tbl[7]  = '{1'b1,1'b0,1'b1, 1'b0,1'b0,4'h0,2'd3,1'b1};
    tbl[8]  = '{1'b1,1'b0,1'b1, 1'b1,1'b0,4'hD,2'd0,1'b1};
    tbl[9]  = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'hD,2'd0,1'b1};
    tbl[10] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'hD,2'd1,1'b1};
    tbl[11] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'hD,2'd1,1'b1};
    tbl[12] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'hD,2'd2,1'b1};
    tbl[13] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'hD,2'd2,1'b1};
    tbl[14] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'hD,2'd3,1'b1};
    tbl[15] = '{1'b1,1'b0,1'b0, 1'b0,1'b0,4'hD,2'd3,1'b1};
    tbl[16] = '{1'b1,1'b0,1'b0, 1'b1,1'b0,4'h0,2'd0,1'b1};
    tbl[17] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,4'h0,2'd0,1'b1};
    for (int i = 0; i < 18; i++) begin
      cyc(tbl[i].en, tbl[i].fs, tbl[i].din);
      chk($sformatf("tbl%0d_d", i), {bus.d3, bus.d2, bus.d1, bus.d0}, tbl[i].d);
      chk($sformatf("tbl%0d_fv", i), bus.frame_valid, tbl[i].fv);
      chk($sformatf("tbl%0d_err", i), bus.sync_err, tbl[i].err);
      chk($sformatf("tbl%0d_slot", i), bus.slot, tbl[i].slot);
      chk($sformatf("tbl%0d_lock", i), bus.locked, tbl[i].lk);
    end

    // Misaligned sync during slot 2 after a good 1101 frame.
    do_reset();
    cyc(1, 1, 1); cyc(1, 0, 1); cyc(1, 0, 0); cyc(1, 0, 0);
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1);
    chk("mis_pre_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 4'hD);
    repeat (4) cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("mis_err", bus.sync_err, 1'b1);
    chk("mis_no_fv", bus.frame_valid, 1'b0);
    chk("mis_hold_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 4'hD);
    chk("mis_lock", bus.locked, 1'b1);
    cyc(1, 0, 1);
    chk("mis_err_drop", bus.sync_err, 1'b0);
    hit = 0;
    for (int n = 3; n <= 20 && hit == 0; n++) begin
      cyc(1, 0, 1);
      if (bus.frame_valid) hit = n;
    end
    chk("mis_fv_latency", hit, 8);
    chk("mis_new_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 4'hF);

    // Asynchronous reset mid-cycle, no clock edge.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_d", {bus.d3, bus.d2, bus.d1, bus.d0}, 4'h0);
    chk("arst_dec", bus.slot_dec, 4'b0001);
    chk("arst_slot", bus.slot, 2'd0);
    chk("arst_lock", bus.locked, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Enable stall for 3 cycles during slot 1.
    hit = 0; dhit = '0;
    for (int k = 0; k < 20 && hit == 0; k++) begin
      if (k < 11) cyc(e_s[k], k == 0, d_s[k]);
      else        cyc(1, 0, 0);
      if (k < 11 && !e_s[k]) begin
        chk("stall_no_fv", bus.frame_valid, 1'b0);
        chk("stall_slot", bus.slot, 2'd1);
      end
      if (bus.frame_valid) begin hit = k + 1; dhit = {bus.d3, bus.d2, bus.d1, bus.d0}; end
    end
    chk("stall_fv_latency", hit, 11);
    chk("stall_d", dhit, 4'hD);

    // Random traffic against the frame model, with extra syncs on the boundary.
    do_reset();
    for (int k = 0; k < 500; k++) begin
      bit e, f, d;
      e = ($urandom % 10) != 0;
      f = ($urandom % 25) == 0;
      if (mlocked && pos == 0 && ($urandom % 3) == 0) f = 1;
      d = $urandom % 2;
      cyc(e, f, d);
    end

`ifdef TDM_DEMUX_TRISTATE_EN
    bus.oe_n = 1'b1;
    #1;
    chk("tri_z", {28'd0, bus.d3, bus.d2, bus.d1, bus.d0}, {28'd0, 4'bzzzz});
    cyc(1, 1, 1); cyc(1, 0, 0); cyc(1, 0, 0); cyc(1, 0, 1);
    cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 1); cyc(1, 0, 0);
    chk("tri_fv_while_z", bus.frame_valid, 1'b1);
    bus.oe_n = 1'b0;
    #1;
    chk("tri_drive", {bus.d3, bus.d2, bus.d1, bus.d0}, 4'b0110);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
